// File: rtl/stream_demux_buffered.sv
// stream_demux_buffered: routes one word per cycle to one of N buffered channels, or broadcasts it to all, with valid/ready backpressure
module stream_demux_buffered #(
    parameter int nrOfBits    = 8,
    parameter int nrOfOutputs = 6,
    parameter int selBits     = 3,
    parameter int cntBits     = 8
) (
    input  logic                            clock,
    input  logic                            resetN,
    input  logic                            enable,
    input  logic                            broadcast,
    input  logic                            inValid,
    output logic                            inReady,
    input  logic [nrOfBits-1:0]             inData,
    input  logic [selBits-1:0]              inSel,
    output logic [nrOfOutputs-1:0]          outValid,
    input  logic [nrOfOutputs-1:0]          outReady,
    output logic [nrOfOutputs*nrOfBits-1:0] outData,
    output logic [cntBits-1:0]              dropCount
);

    logic [nrOfOutputs-1:0]          valid_q, valid_d, free, wr;
    logic [nrOfOutputs*nrOfBits-1:0] data_q, data_d;
    logic [cntBits-1:0]              drop_q, drop_d;
    logic                            in_range, accept;

    // handshake: a slot is free when empty or draining this cycle; out-of-range words are always sunk
    always_comb begin
        free     = ~valid_q | outReady;
        in_range = int'(inSel) < nrOfOutputs;
        inReady  = resetN & enable & (broadcast ? &free : in_range ? free[inSel] : 1'b1);
        accept   = inValid & inReady;
    end

    // next state per slot plus the saturating drop counter
    always_comb begin
        wr      = '0;
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < nrOfOutputs; i++) begin
            wr[i]      = accept & (broadcast | (in_range & (int'(inSel) == i)));
            valid_d[i] = wr[i] | (valid_q[i] & ~outReady[i]);
            data_d[i*nrOfBits +: nrOfBits] = wr[i] ? inData : data_q[i*nrOfBits +: nrOfBits];
        end
        drop_d = (accept & ~broadcast & ~in_range & ~&drop_q) ? drop_q + 1'b1 : drop_q;
    end

    // state registers, cleared asynchronously so buffered words never survive a reset
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign outValid  = valid_q;
    assign outData   = data_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_stream_demux_buffered.sv
// tb_stream_demux_buffered: directed vectors checked against a per-channel behavioural model and literal expectations
module tb_stream_demux_buffered;

    localparam int B = 8;
    localparam int N = 6;
    localparam int S = 3;
    localparam int C = 2;

    logic           clock = 1'b0;
    logic           resetN = 1'b0;
    logic           enable = 1'b0;
    logic           broadcast = 1'b0;
    logic           inValid = 1'b0;
    logic           inReady;
    logic [B-1:0]   inData = '0;
    logic [S-1:0]   inSel = '0;
    logic [N-1:0]   outValid;
    logic [N-1:0]   outReady = '1;
    logic [N*B-1:0] outData;
    logic [C-1:0]   dropCount;

    int vectors = 0;
    int fails = 0;

    bit       mv [N];
    bit [7:0] md [N];
    int       mdrop = 0;

    stream_demux_buffered #(.nrOfBits(B), .nrOfOutputs(N), .selBits(S), .cntBits(C)) dut (
        .clock(clock), .resetN(resetN), .enable(enable), .broadcast(broadcast),
        .inValid(inValid), .inReady(inReady), .inData(inData), .inSel(inSel),
        .outValid(outValid), .outReady(outReady), .outData(outData), .dropCount(dropCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        bit r;
        if (!resetN || !enable) return 1'b0;
        if (broadcast) begin
            r = 1'b1;
            for (int i = 0; i < N; i++) if (mv[i] && !outReady[i]) r = 1'b0;
            return r;
        end
        if (int'(inSel) < N) return !mv[inSel] || outReady[inSel];
        return 1'b1;
    endfunction

    // model: each channel is a one-word box; reset empties all boxes immediately
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N; i++) begin
                mv[i] <= 1'b0;
                md[i] <= 8'h00;
            end
            mdrop <= 0;
        end else begin
            automatic bit acc = inValid && model_ready();
            for (int i = 0; i < N; i++) begin
                automatic bit tgt = acc && (broadcast || int'(inSel) == i);
                if (tgt) begin
                    mv[i] <= 1'b1;
                    md[i] <= inData;
                end else if (mv[i] && outReady[i]) mv[i] <= 1'b0;
            end
            if (acc && !broadcast && int'(inSel) >= N && mdrop < 3) mdrop <= mdrop + 1;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clock) begin
        automatic logic [N-1:0] ev;
        automatic logic [N*B-1:0] ed;
        for (int i = 0; i < N; i++) begin
            ev[i] = mv[i];
            ed[i*B +: B] = md[i];
        end
        chk("m_inReady", 64'(inReady), 64'(model_ready()));
        chk("m_outValid", 64'(outValid), 64'(ev));
        chk("m_outData", 64'(outData), 64'(ed));
        chk("m_dropCount", 64'(dropCount), 64'(mdrop));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [C-1:0] dexp [5];
        dexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step();
        step();
        chk("rst_outValid", 64'(outValid), 64'h0);
        chk("rst_dropCount", 64'(dropCount), 64'h0);
        chk("rst_inReady", 64'(inReady), 64'h0);
        resetN = 1'b1;
        enable = 1'b1;
        outReady = 6'h3f;
        step();
        // unicast
        inSel = 3'd2; inData = 8'hA5; inValid = 1'b1;
        #1 chk("uni_inReady", 64'(inReady), 64'h1);
        step();
        inValid = 1'b0;
        chk("uni_outValid", 64'(outValid), 64'h04);
        chk("uni_slice2", 64'(outData[2*B +: B]), 64'hA5);
        step();
        chk("uni_drained", 64'(outValid), 64'h0);
        // backpressure and channel independence
        outReady = 6'h3b;
        inSel = 3'd2; inData = 8'h11; inValid = 1'b1;
        step();
        inData = 8'h22;
        #1 chk("bp_inReady", 64'(inReady), 64'h0);
        chk("bp_slice2", 64'(outData[2*B +: B]), 64'h11);
        step();
        chk("bp_hold", 64'(outData[2*B +: B]), 64'h11);
        inSel = 3'd4; inData = 8'h33;
        #1 chk("ind_inReady", 64'(inReady), 64'h1);
        step();
        chk("ind_outValid", 64'(outValid), 64'h14);
        chk("ind_slice4", 64'(outData[4*B +: B]), 64'h33);
        inSel = 3'd2; inData = 8'h22; outReady = 6'h3f;
        #1 chk("bp_release", 64'(inReady), 64'h1);
        step();
        inValid = 1'b0;
        chk("bp_next_valid", 64'(outValid), 64'h04);
        chk("bp_next_data", 64'(outData[2*B +: B]), 64'h22);
        step();
        chk("bp_empty", 64'(outValid), 64'h0);
        // broadcast
        broadcast = 1'b1; inData = 8'h5C; inValid = 1'b1; outReady = 6'h3e;
        #1 chk("bc_inReady", 64'(inReady), 64'h1);
        step();
        inData = 8'h77;
        chk("bc_outValid", 64'(outValid), 64'h3f);
        chk("bc_data", 64'(outData), 64'h5C5C5C5C5C5C);
        #1 chk("bc_blocked", 64'(inReady), 64'h0);
        step();
        chk("bc_slot0_held", 64'(outValid), 64'h01);
        chk("bc_still_blocked", 64'(inReady), 64'h0);
        outReady = 6'h3f;
        #1 chk("bc_unblocked", 64'(inReady), 64'h1);
        step();
        inValid = 1'b0; broadcast = 1'b0;
        chk("bc2_data", 64'(outData), 64'h777777777777);
        step();
        chk("bc2_empty", 64'(outValid), 64'h0);
        // out-of-range drops with saturation
        inSel = 3'd7; inValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drop_inReady", 64'(inReady), 64'h1);
            step();
            chk("drop_count", 64'(dropCount), 64'(dexp[k]));
            chk("drop_noValid", 64'(outValid), 64'h0);
        end
        inValid = 1'b0;
        // asynchronous reset with stalled slots
        outReady = 6'h00;
        inValid = 1'b1;
        inSel = 3'd0; inData = 8'h01; step();
        inSel = 3'd1; inData = 8'h02; step();
        inSel = 3'd3; inData = 8'h03; step();
        inValid = 1'b0;
        chk("ar_stalled", 64'(outValid), 64'h0b);
        #2 resetN = 1'b0;
        #1 chk("ar_outValid", 64'(outValid), 64'h0);
        chk("ar_dropCount", 64'(dropCount), 64'h0);
        chk("ar_inReady", 64'(inReady), 64'h0);
        chk("ar_data", 64'(outData), 64'h0);
        step();
        resetN = 1'b1; outReady = 6'h3f; inSel = 3'd0;
        step();
        chk("ar_no_stale", 64'(outValid), 64'h0);
        chk("ar_ready_after", 64'(inReady), 64'h1);
        // global enable
        enable = 1'b0; inValid = 1'b1;
        #1 chk("en_off", 64'(inReady), 64'h0);
        step();
        chk("en_off_novalid", 64'(outValid), 64'h0);
        inValid = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
